// File: rtl/uart_tx_block.sv
// uart_tx_block: parallel-to-serial UART transmitter.
// Frame is start(0), NUM_DATA_BITS data bits LSB-first, optional even parity, stop(1).
// A word is taken on tx_start while tx_ready is high. The start bit appears on the
// next cycle. tx_done pulses in the first idle cycle after the stop bit.
module uart_tx_block #(
   parameter int unsigned NUM_DATA_BITS = 8,
   parameter int unsigned BIT_PERIOD    = 10,
   parameter int unsigned PARITY_EN     = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_DATA_BITS-1:0] tx_data,
   input  logic                     tx_start,
   output logic                     tx_ready,
   output logic                     tx_done,
   output logic                     serial_out
);

   localparam int unsigned PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int unsigned BW = $clog2(NUM_DATA_BITS + 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_PERIOD - 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(NUM_DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                   state;
   logic [NUM_DATA_BITS-1:0] shift_reg;
   logic [NUM_DATA_BITS-1:0] shift_nxt;
   logic                     parity_bit;
   logic [PW-1:0]            period_cnt;
   logic [BW-1:0]            bit_cnt;
   logic                     bit_end;

   // Next data word after one shift, and end of the current bit period.
   assign shift_nxt = shift_reg >> 1;
   assign bit_end   = (period_cnt == PERIOD_LAST);

   // Frame FSM with the bit-period counter, the shift register and the registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         period_cnt <= '0;
         bit_cnt    <= '0;
         serial_out <= 1'b1;
         tx_ready   <= 1'b1;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               serial_out <= 1'b1;
               tx_ready   <= 1'b1;
               if (tx_start) begin
                  shift_reg  <= tx_data;
                  parity_bit <= ^tx_data;
                  bit_cnt    <= '0;
                  period_cnt <= '0;
                  serial_out <= 1'b0;
                  tx_ready   <= 1'b0;
                  state      <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  period_cnt <= '0;
                  serial_out <= shift_reg[0];
                  state      <= DATA;
               end else begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  period_cnt <= '0;
                  shift_reg  <= shift_nxt;
                  bit_cnt    <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
                     if (PARITY_EN != 0) begin
                        serial_out <= parity_bit;
                        state      <= PARITY;
                     end else begin
                        serial_out <= 1'b1;
                        state      <= STOP;
                     end
                  end else begin
                     serial_out <= shift_nxt[0];
                  end
               end else begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end

            PARITY: begin
               if (bit_end) begin
                  period_cnt <= '0;
                  serial_out <= 1'b1;
                  state      <= STOP;
               end else begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end

            STOP: begin
               if (bit_end) begin
                  period_cnt <= '0;
                  serial_out <= 1'b1;
                  tx_ready   <= 1'b1;
                  tx_done    <= 1'b1;
                  state      <= IDLE;
               end else begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end

            default: begin
               period_cnt <= '0;
               bit_cnt    <= '0;
               serial_out <= 1'b1;
               tx_ready   <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_block.sv
// tb_uart_tx_block: directed bench for uart_tx_block.
// u_dut uses the default parameters, u_dut_par uses BIT_PERIOD=4 with parity.
module tb_uart_tx_block;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data0, tx_data1;
   logic       tx_start0, tx_start1;
   logic       tx_ready0, tx_ready1;
   logic       tx_done0, tx_done1;
   logic       so0, so1;

   logic       mon_sel;
   logic       so_m, rdy_m, done_m;

   int checks;
   int errors;

   uart_tx_block u_dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data0),
      .tx_start   (tx_start0),
      .tx_ready   (tx_ready0),
      .tx_done    (tx_done0),
      .serial_out (so0)
   );

   uart_tx_block #(
      .NUM_DATA_BITS (8),
      .BIT_PERIOD    (4),
      .PARITY_EN     (1)
   ) u_dut_par (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data1),
      .tx_start   (tx_start1),
      .tx_ready   (tx_ready1),
      .tx_done    (tx_done1),
      .serial_out (so1)
   );

   assign so_m   = mon_sel ? so1       : so0;
   assign rdy_m  = mon_sel ? tx_ready1 : tx_ready0;
   assign done_m = mon_sel ? tx_done1  : tx_done0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Request a word; returns just after the accepting edge. hold keeps tx_start high.
   task automatic send(input logic sel, input logic [7:0] d, input logic hold);
      @(posedge clk);
      #1;
      mon_sel = sel;
      if (sel) begin tx_data1 = d; tx_start1 = 1'b1; end
      else     begin tx_data0 = d; tx_start0 = 1'b1; end
      #1;
      checks++;
      if (rdy_m !== 1'b1) begin
         errors++;
         $display("FAIL send_ready data %h: tx_ready=%b required 1", d, rdy_m);
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         if (sel) tx_start1 = 1'b0;
         else     tx_start0 = 1'b0;
      end
   endtask

   // Checks every cycle of one frame (line, ready, done), then the tx_done cycle.
   task automatic check_frame(input logic sel, input logic [7:0] data, input int bp,
                              input int par_en, input logic exp_par, input string name);
      int   nbits;
      logic exp_bit;
      mon_sel = sel;
      nbits   = 2 + 8 + par_en;
      for (int b = 0; b < nbits; b++) begin
         if (b == 0)                          exp_bit = 1'b0;
         else if (b <= 8)                     exp_bit = data[b-1];
         else if (par_en != 0 && b == 9)      exp_bit = exp_par;
         else                                 exp_bit = 1'b1;
         for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            checks++;
            if ({so_m, rdy_m, done_m} !== {exp_bit, 2'b00}) begin
               errors++;
               $display("FAIL %s bit %0d cycle %0d: so/ready/done=%b required %b",
                        name, b, c, {so_m, rdy_m, done_m}, {exp_bit, 2'b00});
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({so_m, rdy_m, done_m} !== 3'b111) begin
         errors++;
         $display("FAIL %s done_cycle: so/ready/done=%b required 111", name, {so_m, rdy_m, done_m});
      end
   endtask

   // Line must stay idle (high, ready, no done) for n cycles.
   task automatic idle_check(input logic sel, input int n, input string name);
      mon_sel = sel;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if ({so_m, rdy_m, done_m} !== 3'b110) begin
            errors++;
            $display("FAIL %s idle cycle %0d: so/ready/done=%b required 110", name, i, {so_m, rdy_m, done_m});
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if ({so0, tx_ready0, tx_done0, so1, tx_ready1, tx_done1} !== 6'b110110) begin
         errors++;
         $display("FAIL reset_state: outputs=%b required 110110",
                  {so0, tx_ready0, tx_done0, so1, tx_ready1, tx_done1});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_check(1'b0, 15, "reset_release");
      // Async reset in the middle of an all-zero frame, between clock edges.
      send(1'b0, 8'h00, 1'b0);
      repeat (15) @(negedge clk);
      checks++;
      if (so0 !== 1'b0) begin
         errors++;
         $display("FAIL async_pre: serial_out=%b required 0", so0);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({so0, tx_ready0, tx_done0} !== 3'b110) begin
         errors++;
         $display("FAIL async_reset: so/ready/done=%b required 110", {so0, tx_ready0, tx_done0});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_check(1'b0, 30, "async_release");
   endtask

   task automatic test_single_frame();
      send(1'b0, 8'hA5, 1'b0);
      check_frame(1'b0, 8'hA5, 10, 0, 1'b0, "frame_a5");
      idle_check(1'b0, 5, "after_a5");
   endtask

   task automatic test_busy_ignore();
      send(1'b0, 8'h3C, 1'b0);
      fork
         check_frame(1'b0, 8'h3C, 10, 0, 1'b0, "busy_3c");
         begin
            repeat (25) @(posedge clk);
            #1;
            tx_data0  = 8'hFF;
            tx_start0 = 1'b1;
            @(posedge clk);
            #1;
            tx_start0 = 1'b0;
         end
      join
      idle_check(1'b0, 20, "busy_no_second");
   endtask

   task automatic test_back_to_back();
      send(1'b0, 8'h01, 1'b1);
      tx_data0 = 8'h80;
      check_frame(1'b0, 8'h01, 10, 0, 1'b0, "b2b_01");
      @(posedge clk);
      #1;
      tx_start0 = 1'b0;
      check_frame(1'b0, 8'h80, 10, 0, 1'b0, "b2b_80");
      idle_check(1'b0, 10, "after_b2b");
   endtask

   task automatic test_parity();
      send(1'b1, 8'h07, 1'b0);
      check_frame(1'b1, 8'h07, 4, 1, 1'b1, "par_07");
      idle_check(1'b1, 3, "after_par_07");
      send(1'b1, 8'h03, 1'b0);
      check_frame(1'b1, 8'h03, 4, 1, 1'b0, "par_03");
      idle_check(1'b1, 3, "after_par_03");
   endtask

   task automatic test_reset_mid_frame();
      send(1'b0, 8'h55, 1'b0);
      repeat (45) @(negedge clk);
      checks++;
      if (so0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit3: serial_out=%b required 0", so0);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({so0, tx_ready0, tx_done0} !== 3'b110) begin
         errors++;
         $display("FAIL mid_reset: so/ready/done=%b required 110", {so0, tx_ready0, tx_done0});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_check(1'b0, 5, "mid_release");
      send(1'b0, 8'hAA, 1'b0);
      check_frame(1'b0, 8'hAA, 10, 0, 1'b0, "post_reset_aa");
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      mon_sel   = 1'b0;
      tx_data0  = 8'h00;
      tx_data1  = 8'h00;
      tx_start0 = 1'b0;
      tx_start1 = 1'b0;
      rst       = 1'b1;
      test_reset();
      test_single_frame();
      test_busy_ignore();
      test_back_to_back();
      test_parity();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
